// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_arb_pkg
// Brief  : Shared state encoding and UART register map for uart_tx_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      POLL    = 2'd2,
      WRITE   = 2'd3
   } arb_state_t;

   localparam logic [3:0] UART_OFF_DATA       = 4'h0;
   localparam logic [3:0] UART_OFF_STATUS     = 4'h4;
   localparam int         STATUS_TX_READY_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority encoder; first set request at or
//          above i_start, wrapping modulo N_REQ.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 3
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_start,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   // Smallest rotational distance from the start pointer wins.
   always_comb begin
      int w_best;
      int w_dist;
      w_best  = N_REQ;
      w_dist  = 0;
      o_found = 1'b0;
      o_idx   = '0;
      for (int j = 0; j < N_REQ; j++) begin
         w_dist = (j - int'(i_start) + N_REQ) % N_REQ;
         if (i_req[j] && (w_dist < w_best)) begin
            w_best  = w_dist;
            o_found = 1'b1;
            o_idx   = IDX_W'(j);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin MMIO master sharing one UART transmitter between
//          N_REQ byte streams, with per-message locking and poll timeout.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int          N_REQ      = 4,
   parameter logic [31:0] UART_BASE  = 32'h1000_0000,
   parameter logic [15:0] POLL_LIMIT = 16'd65535
) (
   input  logic               CLOCK_50MHz,
   input  logic               RESET,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic               AS_L,
   output logic               WE_L,
   output logic [31:0]        Address,
   output logic [31:0]        WrData,
   input  logic [31:0]        RdData,
   output logic               busy,
   output logic [2:0]         grant_id,
   output logic               timeout_err,
   input  logic               err_clr
);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;
   logic [2:0]  w_grant_nxt;
   logic        r_lock;
   logic [2:0]  r_rr_ptr;
   logic [2:0]  w_rr_nxt;
   logic [15:0] r_poll_cnt;
   logic [7:0]  r_hold_data;
   logic        r_hold_last;
   logic        w_found;
   logic [2:0]  w_pick_idx;
   logic        w_lock_valid;
   logic [7:0]  w_sel_data;
   logic        w_sel_last;
   logic        w_tx_ready;
   logic        w_timeout;
   logic        w_msg_end;
   logic        w_unused_rd;

   assign w_tx_ready  = RdData[STATUS_TX_READY_BIT];
   assign w_unused_rd = ^RdData[31:1];
   assign w_rr_nxt    = (grant_id == 3'(N_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
   assign w_msg_end   = (r_state == WRITE) || w_timeout;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (3)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_start (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_pick_idx)
   );

   // Mux out the granted requester's inputs.
   always_comb begin
      w_lock_valid = 1'b0;
      w_sel_data   = '0;
      w_sel_last   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id == 3'(i)) begin
            w_lock_valid = req_valid[i];
            w_sel_data   = req_data[8*i +: 8];
            w_sel_last   = req_last[i];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = grant_id;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_lock) begin
               if (w_lock_valid) w_state_nxt = CAPTURE;
            end else if (w_found) begin
               w_state_nxt = CAPTURE;
               w_grant_nxt = w_pick_idx;
            end
         end
         CAPTURE: w_state_nxt = POLL;
         POLL: begin
            if (w_tx_ready) begin
               w_state_nxt = WRITE;
            end else if (r_poll_cnt == POLL_LIMIT) begin
               w_state_nxt = IDLE;
               w_timeout   = 1'b1;
            end
         end
         WRITE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bus outputs are registered from the next state so they line up with it.
   always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
      if (RESET) begin
         r_state     <= IDLE;
         grant_id    <= 3'd0;
         r_lock      <= 1'b0;
         r_rr_ptr    <= 3'd0;
         r_poll_cnt  <= 16'd0;
         r_hold_data <= 8'd0;
         r_hold_last <= 1'b0;
         req_ready   <= '0;
         AS_L        <= 1'b1;
         WE_L        <= 1'b1;
         Address     <= 32'd0;
         WrData      <= 32'd0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         grant_id <= w_grant_nxt;
         busy     <= (w_state_nxt != IDLE);
         for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] <= (w_state_nxt == CAPTURE) && (w_grant_nxt == 3'(i));
         end

         if (r_state == CAPTURE) begin
            r_hold_data <= w_sel_data;
            r_hold_last <= w_sel_last;
            r_poll_cnt  <= 16'd0;
         end else if ((r_state == POLL) && !w_tx_ready && !w_timeout) begin
            r_poll_cnt <= r_poll_cnt + 16'd1;
         end

         if (w_msg_end) begin
            if (r_hold_last) begin
               r_lock   <= 1'b0;
               r_rr_ptr <= w_rr_nxt;
            end else begin
               r_lock <= 1'b1;
            end
         end

         if (w_timeout)    timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;

         AS_L <= !((w_state_nxt == POLL) || (w_state_nxt == WRITE));
         WE_L <= (w_state_nxt != WRITE);
         if (w_state_nxt == POLL) begin
            Address <= UART_BASE + {28'h0, UART_OFF_STATUS};
         end else if (w_state_nxt == WRITE) begin
            Address <= UART_BASE + {28'h0, UART_OFF_DATA};
            WrData  <= {24'h0, r_hold_data};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Self-checking bench: requester/UART models and a message-level
//          round-robin reference for uart_tx_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int          N    = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [15:0] PL   = 16'd600;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic            as_l, we_l;
   logic [31:0]     address, wrdata, rd_data;
   logic            busy;
   logic [2:0]      grant_id;
   logic            timeout_err;
   logic            err_clr;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ      (N),
      .UART_BASE  (BASE),
      .POLL_LIMIT (PL)
   ) dut (
      .CLOCK_50MHz (clk),
      .RESET       (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .AS_L        (as_l),
      .WE_L        (we_l),
      .Address     (address),
      .WrData      (wrdata),
      .RdData      (rd_data),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   int         checks = 0;
   int         failures = 0;
   logic [8:0] rq [N][$];
   int         exp_id[$];
   logic [7:0] exp_data[$];
   int         m_ptr = 0;
   int         cyc = 0;
   int         reads = 0, notready_reads = 0, writes = 0;
   int         busy_left = 0;
   bit         stuck = 0, rnd_ready = 0;
   bit         pend [N];
   int         last_ready_cyc = 0, last_ready_id = 0, last_write_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      logic [8:0] e;
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0) begin
            e = rq[i][0];
            req_valid[i]      = 1'b1;
            req_data[8*i +: 8] = e[7:0];
            req_last[i]       = e[8];
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   // One clock: requester handshakes, UART model and bus monitor at negedge.
   task automatic step();
      logic [8:0] e;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (pend[i]) begin
            pend[i] = 1'b0;
            e = rq[i].pop_front();
         end
      end
      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) begin
            pend[i] = 1'b1;
            last_ready_cyc = cyc;
            last_ready_id  = i;
         end
      end
      rd_data = 32'd0;
      if (!as_l && we_l) begin
         reads++;
         chk("poll_addr", address, BASE + 32'h4);
         if (!stuck && busy_left == 0 && (!rnd_ready || $urandom_range(0, 2) != 0)) begin
            rd_data = 32'd1;
         end else begin
            notready_reads++;
            if (busy_left > 0) busy_left--;
         end
      end
      if (!as_l && !we_l) begin
         writes++;
         last_write_cyc = cyc;
         chk("wr_addr", address, BASE);
         if (exp_id.size() > 0) begin
            chk("wr_data", wrdata, {24'h0, exp_data[0]});
            chk("wr_src", {29'd0, grant_id}, exp_id[0]);
            void'(exp_id.pop_front());
            void'(exp_data.pop_front());
         end
      end
      drive_reqs();
   endtask

   // Reference: whole messages in round-robin order from the message pointer.
   task automatic build_expect();
      logic [8:0] cq [N][$];
      logic [8:0] e;
      int idx;
      bit found;
      for (int i = 0; i < N; i++) cq[i] = rq[i];
      forever begin
         found = 0;
         idx   = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && cq[(m_ptr + k) % N].size() > 0) begin
               found = 1;
               idx   = (m_ptr + k) % N;
            end
         end
         if (!found) break;
         do begin
            e = cq[idx].pop_front();
            exp_id.push_back(idx);
            exp_data.push_back(e[7:0]);
         end while (!e[8]);
         m_ptr = (idx + 1) % N;
      end
   endtask

   task automatic run_phase(input string tag);
      int w0, n, budget;
      bit pending;
      w0 = writes;
      build_expect();
      n = exp_id.size();
      drive_reqs();
      budget = 4000;
      pending = 1;
      while (pending && budget > 0) begin
         step();
         budget--;
         pending = busy || (exp_id.size() > 0);
         for (int i = 0; i < N; i++) if (rq[i].size() > 0) pending = 1;
      end
      chk({tag, "_writes"}, writes - w0, n);
      chk({tag, "_drained"}, exp_id.size(), 0);
   endtask

   task automatic push_msg(input int r, input int len);
      logic [8:0] e;
      for (int b = 0; b < len; b++) begin
         e[7:0] = 8'($urandom_range(0, 255));
         e[8]   = (b == len - 1);
         rq[r].push_back(e);
      end
   endtask

   initial begin
      int c0, r0, nr0, w0, budget;
      logic [8:0] e;
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
      rd_data = 32'd0; err_clr = 1'b0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_as_l", {31'd0, as_l}, 32'd1);
      chk("rst_we_l", {31'd0, we_l}, 32'd1);
      chk("rst_addr", address, 32'd0);
      chk("rst_wrdata", wrdata, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant", {29'd0, grant_id}, 32'd0);
      chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
      rst = 1'b0;
      step();

      // Round robin: all four valid, requester 0 has a second message.
      for (int i = 0; i < N; i++) begin e = {1'b1, 8'h30 + 8'(i)}; rq[i].push_back(e); end
      e = 9'h1_5A; rq[0].push_back(e);
      run_phase("rr");

      // Single byte latency.
      e = 9'h1_41; rq[0].push_back(e);
      c0 = cyc;
      run_phase("single");
      chk("single_ready_cyc", last_ready_cyc - c0, 1);
      chk("single_ready_id", last_ready_id, 0);
      chk("single_write_cyc", last_write_cyc - c0, 3);

      // Move the pointer past requester 1, then a locked 3-byte message on 2.
      push_msg(1, 1);
      run_phase("pre_lock");
      e = 9'h0_A0; rq[2].push_back(e);
      e = 9'h0_A1; rq[2].push_back(e);
      e = 9'h1_A2; rq[2].push_back(e);
      push_msg(0, 1);
      push_msg(1, 1);
      run_phase("lock");

      // Random message mixes with a jittery UART.
      rnd_ready = 1;
      for (int round = 0; round < 6; round++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) push_msg(i, $urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) push_msg(i, $urandom_range(1, 3));
         end
         run_phase("rand");
      end
      rnd_ready = 0;

      // Busy UART for 433 polls.
      busy_left = 433;
      nr0 = notready_reads;
      r0  = reads;
      push_msg(1, 1);
      run_phase("busy");
      chk("busy_notready_polls", notready_reads - nr0, 433);
      chk("busy_total_polls", reads - r0, 434);
      chk("busy_tmo", {31'd0, timeout_err}, 32'd0);

      // Timeout with TX_READY stuck low: byte dropped, pointer advances.
      stuck = 1;
      r0 = reads;
      w0 = writes;
      e = 9'h1_EE; rq[3].push_back(e);
      drive_reqs();
      budget = 1000;
      while (!timeout_err && budget > 0) begin step(); budget--; end
      chk("tmo_set", {31'd0, timeout_err}, 32'd1);
      chk("tmo_idle", {31'd0, busy}, 32'd0);
      chk("tmo_polls", reads - r0, 32'(PL) + 1);
      chk("tmo_no_write", writes - w0, 0);
      m_ptr = 0;
      stuck = 0;
      step();
      chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("tmo_clear", {31'd0, timeout_err}, 32'd0);

      // Asynchronous reset during POLL.
      busy_left = 50;
      push_msg(0, 1);
      drive_reqs();
      budget = 20;
      while (as_l && budget > 0) begin step(); budget--; end
      step();
      chk("pre_rst_poll", {31'd0, as_l}, 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_as_l", {31'd0, as_l}, 32'd1);
      chk("arst_ready", {28'd0, req_ready}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      busy_left = 0;
      m_ptr = 0;
      for (int i = 0; i < N; i++) begin rq[i].delete(); pend[i] = 1'b0; end
      exp_id.delete();
      exp_data.delete();
      step();
      step();
      rst = 1'b0;
      step();
      push_msg(2, 1);
      run_phase("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
